// File: rtl/rtc_bus_sequencer.sv
// Sequencer for the RTC chip's multiplexed address/data bus: writes or reads all nine
// time/date registers as ten strobed transactions and reports completion to the register bank.
module rtc_bus_sequencer #(
   parameter int T_PULSE = 4,
   parameter int T_GAP   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Listo_esc,
   input  logic       lee,
   input  logic [7:0] ano,
   input  logic [7:0] mes,
   input  logic [7:0] dia,
   input  logic [7:0] horas,
   input  logic [7:0] minutos,
   input  logic [7:0] segundos,
   input  logic [7:0] ht,
   input  logic [7:0] mt,
   input  logic [7:0] st,
   input  logic [7:0] ad_in,
   output logic       cs_n,
   output logic       rd_n,
   output logic       wr_n,
   output logic       ad_n,
   output logic [7:0] ad_out,
   output logic       ad_oe,
   output logic [7:0] anole,
   output logic [7:0] mesle,
   output logic [7:0] diale,
   output logic [7:0] horasle,
   output logic [7:0] minutosle,
   output logic [7:0] segundosle,
   output logic [7:0] htle,
   output logic [7:0] mtle,
   output logic [7:0] stle,
   output logic       Listo_es,
   output logic       Listo_lec,
   output logic       ocupado
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_A_STB = 3'd1,
      S_A_GAP = 3'd2,
      S_D_STB = 3'd3,
      S_D_GAP = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam logic [3:0] PULSE_LD = 4'(T_PULSE - 1);
   localparam logic [3:0] GAP_LD   = 4'(T_GAP - 1);
   localparam logic [3:0] LAST_TX  = 4'd9;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] idx_q, idx_d;
   logic       wr_mode_q, wr_mode_d;
   logic [7:0] shadow_q [9];
   logic [7:0] shadow_d [9];
   logic [7:0] le_q [9];
   logic [7:0] le_d [9];
   logic       cs_n_q, cs_n_d;
   logic       rd_n_q, rd_n_d;
   logic       wr_n_q, wr_n_d;
   logic       ad_n_q, ad_n_d;
   logic       ad_oe_q, ad_oe_d;
   logic [7:0] ad_out_q, ad_out_d;
   logic       listo_es_q, listo_es_d;
   logic       listo_lec_q, listo_lec_d;
   logic       ocupado_q, ocupado_d;

   // Register slot order is seconds first; the read sequence shifts slots by one behind its command.
   function automatic logic [7:0] tx_addr(input logic wr_mode, input logic [3:0] idx);
      logic [3:0] slot;
      logic [7:0] addr;
      if (wr_mode) begin
         slot = idx;
      end else begin
         slot = idx - 4'd1;
      end
      case (slot)
         4'd0:    addr = 8'h21;
         4'd1:    addr = 8'h22;
         4'd2:    addr = 8'h23;
         4'd3:    addr = 8'h24;
         4'd4:    addr = 8'h25;
         4'd5:    addr = 8'h26;
         4'd6:    addr = 8'h41;
         4'd7:    addr = 8'h42;
         4'd8:    addr = 8'h43;
         default: addr = wr_mode ? 8'hF1 : 8'hF0;
      endcase
      return addr;
   endfunction

   // State, counters, shadow and all bus/handshake outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         idx_q       <= 4'd0;
         wr_mode_q   <= 1'b0;
         for (int i = 0; i < 9; i++) begin
            shadow_q[i] <= 8'h00;
            le_q[i]     <= 8'h00;
         end
         cs_n_q      <= 1'b1;
         rd_n_q      <= 1'b1;
         wr_n_q      <= 1'b1;
         ad_n_q      <= 1'b1;
         ad_oe_q     <= 1'b0;
         ad_out_q    <= 8'h00;
         listo_es_q  <= 1'b0;
         listo_lec_q <= 1'b0;
         ocupado_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         wr_mode_q   <= wr_mode_d;
         shadow_q    <= shadow_d;
         le_q        <= le_d;
         cs_n_q      <= cs_n_d;
         rd_n_q      <= rd_n_d;
         wr_n_q      <= wr_n_d;
         ad_n_q      <= ad_n_d;
         ad_oe_q     <= ad_oe_d;
         ad_out_q    <= ad_out_d;
         listo_es_q  <= listo_es_d;
         listo_lec_q <= listo_lec_d;
         ocupado_q   <= ocupado_d;
      end
   end

   // Next-state: phase sequencing, write snapshot on acceptance, read capture on last D_STB cycle
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      wr_mode_d = wr_mode_q;
      shadow_d  = shadow_q;
      case (state_q)
         S_IDLE: begin
            if (Listo_esc) begin
               state_d     = S_A_STB;
               cnt_d       = PULSE_LD;
               idx_d       = 4'd0;
               wr_mode_d   = 1'b1;
               shadow_d[0] = segundos;
               shadow_d[1] = minutos;
               shadow_d[2] = horas;
               shadow_d[3] = dia;
               shadow_d[4] = mes;
               shadow_d[5] = ano;
               shadow_d[6] = st;
               shadow_d[7] = mt;
               shadow_d[8] = ht;
            end else if (lee) begin
               state_d   = S_A_STB;
               cnt_d     = PULSE_LD;
               idx_d     = 4'd0;
               wr_mode_d = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_A_STB: begin
            if (cnt_q == 4'd0) begin
               state_d = S_A_GAP;
               cnt_d   = GAP_LD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_A_GAP: begin
            if (cnt_q == 4'd0) begin
               state_d = S_D_STB;
               cnt_d   = PULSE_LD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_D_STB: begin
            if (cnt_q == 4'd0) begin
               state_d = S_D_GAP;
               cnt_d   = GAP_LD;
               if (!wr_mode_q && (idx_q != 4'd0)) begin
                  shadow_d[idx_q - 4'd1] = ad_in;
               end else begin
                  shadow_d = shadow_q;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_D_GAP: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else if (idx_q == LAST_TX) begin
               state_d = S_DONE;
            end else begin
               state_d = S_A_STB;
               cnt_d   = PULSE_LD;
               idx_d   = idx_q + 4'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            idx_d   = 4'd0;
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = 4'd0;
         end
      endcase
   end

   // Output decode from the next state so the registered bus lines up with the FSM phase
   always_comb begin
      cs_n_d      = 1'b1;
      rd_n_d      = 1'b1;
      wr_n_d      = 1'b1;
      ad_n_d      = 1'b1;
      ad_oe_d     = 1'b0;
      ad_out_d    = 8'h00;
      listo_es_d  = 1'b0;
      listo_lec_d = 1'b0;
      ocupado_d   = 1'b0;
      le_d        = le_q;
      case (state_d)
         S_A_STB, S_A_GAP: begin
            cs_n_d    = 1'b0;
            ad_n_d    = 1'b0;
            wr_n_d    = (state_d == S_A_STB) ? 1'b0 : 1'b1;
            ad_oe_d   = 1'b1;
            ad_out_d  = tx_addr(wr_mode_d, idx_d);
            ocupado_d = 1'b1;
         end
         S_D_STB: begin
            cs_n_d    = 1'b0;
            ocupado_d = 1'b1;
            if (wr_mode_d) begin
               ad_oe_d = 1'b1;
               wr_n_d  = 1'b0;
               if (idx_d < LAST_TX) begin
                  ad_out_d = shadow_q[idx_d];
               end else begin
                  ad_out_d = 8'hF1;
               end
            end else if (idx_d == 4'd0) begin
               ad_oe_d  = 1'b1;
               wr_n_d   = 1'b0;
               ad_out_d = 8'hF0;
            end else begin
               rd_n_d = 1'b0;
            end
         end
         S_D_GAP: begin
            ocupado_d = 1'b1;
         end
         S_DONE: begin
            if (wr_mode_d) begin
               listo_es_d = 1'b1;
            end else begin
               listo_lec_d = 1'b1;
               le_d        = shadow_q;
            end
         end
         default: begin
            ocupado_d = 1'b0;
         end
      endcase
   end

   assign cs_n       = cs_n_q;
   assign rd_n       = rd_n_q;
   assign wr_n       = wr_n_q;
   assign ad_n       = ad_n_q;
   assign ad_oe      = ad_oe_q;
   assign ad_out     = ad_out_q;
   assign Listo_es   = listo_es_q;
   assign Listo_lec  = listo_lec_q;
   assign ocupado    = ocupado_q;
   assign segundosle = le_q[0];
   assign minutosle  = le_q[1];
   assign horasle    = le_q[2];
   assign diale      = le_q[3];
   assign mesle      = le_q[4];
   assign anole      = le_q[5];
   assign stle       = le_q[6];
   assign mtle       = le_q[7];
   assign htle       = le_q[8];

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: directed and randomized write/read sequences on two
// parameterisations, checked against a transaction-level model of the RTC bus.
module tb_rtc_bus_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       reset;
   logic       req_w0, req_r0, req_w1;
   logic [7:0] wv [9];
   logic [7:0] exp_wv [9];
   logic [7:0] rtc_mem [256];
   logic [7:0] lat_addr;
   logic [7:0] ad_in0;
   assign ad_in0 = rtc_mem[lat_addr];

   logic       cs_n0, rd_n0, wr_n0, ad_n0, ad_oe0, les0, llec0, ocup0;
   logic [7:0] ad_out0;
   logic [7:0] le0 [9];
   logic       cs_n1, rd_n1, wr_n1, ad_n1, ad_oe1, les1, llec1, ocup1;
   logic [7:0] ad_out1;
   logic [7:0] le1 [9];
   logic [71:0] le_flat0, le_flat1;
   assign le_flat0 = {le0[8], le0[7], le0[6], le0[5], le0[4], le0[3], le0[2], le0[1], le0[0]};
   assign le_flat1 = {le1[8], le1[7], le1[6], le1[5], le1[4], le1[3], le1[2], le1[1], le1[0]};

   rtc_bus_sequencer u_dut0 (
      .clk(clk), .reset(reset), .Listo_esc(req_w0), .lee(req_r0),
      .ano(wv[5]), .mes(wv[4]), .dia(wv[3]), .horas(wv[2]), .minutos(wv[1]), .segundos(wv[0]),
      .ht(wv[8]), .mt(wv[7]), .st(wv[6]), .ad_in(ad_in0),
      .cs_n(cs_n0), .rd_n(rd_n0), .wr_n(wr_n0), .ad_n(ad_n0), .ad_out(ad_out0), .ad_oe(ad_oe0),
      .anole(le0[5]), .mesle(le0[4]), .diale(le0[3]), .horasle(le0[2]), .minutosle(le0[1]),
      .segundosle(le0[0]), .htle(le0[8]), .mtle(le0[7]), .stle(le0[6]),
      .Listo_es(les0), .Listo_lec(llec0), .ocupado(ocup0)
   );

   rtc_bus_sequencer #(.T_PULSE(1), .T_GAP(2)) u_dut1 (
      .clk(clk), .reset(reset), .Listo_esc(req_w1), .lee(1'b0),
      .ano(wv[5]), .mes(wv[4]), .dia(wv[3]), .horas(wv[2]), .minutos(wv[1]), .segundos(wv[0]),
      .ht(wv[8]), .mt(wv[7]), .st(wv[6]), .ad_in(8'h00),
      .cs_n(cs_n1), .rd_n(rd_n1), .wr_n(wr_n1), .ad_n(ad_n1), .ad_out(ad_out1), .ad_oe(ad_oe1),
      .anole(le1[5]), .mesle(le1[4]), .diale(le1[3]), .horasle(le1[2]), .minutosle(le1[1]),
      .segundosle(le1[0]), .htle(le1[8]), .mtle(le1[7]), .stle(le1[6]),
      .Listo_es(les1), .Listo_lec(llec1), .ocupado(ocup1)
   );

   int checks = 0;
   int failures = 0;

   // Bus monitor state, rebuilt for every sequence
   logic        prev_strobe;
   int          len_cnt, gap_cnt;
   bit          gap_valid, bad;
   int          len_q [$];
   int          gap_q [$];
   logic [16:0] log_q [$];
   logic [7:0]  cur_addr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Register map from the RTC datasheet: time/date block at 0x21.., alarm block at 0x41..
   function automatic logic [7:0] slot_addr(input int k);
      return (k < 6) ? 8'(8'h21 + k) : 8'(8'h41 + (k - 6));
   endfunction

   task automatic sample(input logic wr_n, input logic rd_n, input logic ad_n, input logic cs_n,
                         input logic ad_oe, input logic ocup, input logic [7:0] ad_out);
      logic strobe;
      strobe = !wr_n || !rd_n;
      if (strobe && !prev_strobe) begin
         if (gap_valid) gap_q.push_back(gap_cnt);
         len_cnt = 1;
         if (!ad_n) begin
            cur_addr = ad_out;
            lat_addr = ad_out;
            if (!ad_oe || wr_n) bad = 1'b1;
         end else if (!wr_n) begin
            log_q.push_back({1'b0, cur_addr, ad_out});
         end else begin
            log_q.push_back({1'b1, cur_addr, 8'h00});
         end
      end else if (strobe) begin
         len_cnt++;
      end else if (prev_strobe) begin
         len_q.push_back(len_cnt);
         gap_cnt   = 1;
         gap_valid = 1'b1;
      end else begin
         gap_cnt++;
      end
      if (!ocup) gap_valid = 1'b0;
      if ((!rd_n && ad_oe) || (strobe && cs_n) || (!wr_n && !rd_n)) bad = 1'b1;
      prev_strobe = strobe;
   endtask

   task automatic run_seq(input bit d1, input bit w, input bit r, input int tp, input int tg,
                          input string tag);
      int n, done_cyc, tx, nbad;
      bit seen_done, saw_lec, le_moved;
      logic [71:0] le_start;
      logic [16:0] exp_e;
      tx = 2 * (tp + tg);
      log_q.delete(); len_q.delete(); gap_q.delete();
      prev_strobe = 1'b0; gap_valid = 1'b0; bad = 1'b0;
      seen_done = 0; saw_lec = 0; le_moved = 0; done_cyc = 0;
      le_start = le_flat0;
      exp_wv = wv;
      @(posedge clk); #1;
      if (d1) req_w1 = w;
      else begin req_w0 = w; req_r0 = r; end
      n = cyc;
      @(posedge clk); #1;
      req_w0 = 1'b0; req_r0 = 1'b0; req_w1 = 1'b0;
      foreach (wv[i]) wv[i] = 8'($urandom);
      for (int i = 0; i < 400 && !seen_done; i++) begin
         @(negedge clk);
         if (d1) sample(wr_n1, rd_n1, ad_n1, cs_n1, ad_oe1, ocup1, ad_out1);
         else    sample(wr_n0, rd_n0, ad_n0, cs_n0, ad_oe0, ocup0, ad_out0);
         if (i == 0) begin
            chk($sformatf("%s ocupado_n+1", tag), d1 ? ocup1 : ocup0, 1);
            chk($sformatf("%s cs_n_n+1", tag), d1 ? cs_n1 : cs_n0, 0);
         end
         if (d1 ? (les1 || llec1) : (les0 || llec0)) begin
            seen_done = 1;
            done_cyc  = cyc;
         end else if (le_flat0 != le_start) begin
            le_moved = 1;
         end
         if (llec0 || llec1) saw_lec = 1;
      end
      chk($sformatf("%s done_seen", tag), seen_done, 1);
      chk($sformatf("%s latency", tag), done_cyc - n, 10 * tx + 1);
      chk($sformatf("%s ocupado_at_done", tag), d1 ? ocup1 : ocup0, 0);
      chk($sformatf("%s Listo_es", tag), d1 ? les1 : les0, w);
      chk($sformatf("%s Listo_lec_seen", tag), saw_lec, !w);
      chk($sformatf("%s le_held", tag), le_moved, 0);
      if (!d1 && !w) begin
         for (int k = 0; k < 9; k++)
            chk($sformatf("%s le%0d", tag, k), le_flat0[8*k +: 8], rtc_mem[slot_addr(k)]);
      end
      chk($sformatf("%s strobes", tag), len_q.size(), 20);
      chk($sformatf("%s gaps", tag), gap_q.size(), 19);
      nbad = 0;
      foreach (len_q[i]) if (len_q[i] != tp) nbad++;
      foreach (gap_q[i]) if (gap_q[i] != tg) nbad++;
      chk($sformatf("%s timing_errs", tag), nbad, 0);
      chk($sformatf("%s bus_rule", tag), bad, 0);
      chk($sformatf("%s tx_count", tag), log_q.size(), 10);
      for (int t = 0; t < 10 && t < log_q.size(); t++) begin
         if (w) exp_e = (t < 9) ? {1'b0, slot_addr(t), exp_wv[t]} : {1'b0, 8'hF1, 8'hF1};
         else   exp_e = (t == 0) ? {1'b0, 8'hF0, 8'hF0} : {1'b1, slot_addr(t - 1), 8'h00};
         chk($sformatf("%s tx%0d", tag, t), log_q[t], exp_e);
      end
      @(negedge clk);
      chk($sformatf("%s pulse_width", tag), d1 ? (les1 | llec1) : (les0 | llec0), 0);
      chk($sformatf("%s idle_after", tag), d1 ? cs_n1 : cs_n0, 1);
   endtask

   initial begin
      reset = 1'b1; req_w0 = 1'b0; req_r0 = 1'b0; req_w1 = 1'b0; lat_addr = 8'h00;
      foreach (wv[i]) wv[i] = 8'h00;
      foreach (rtc_mem[i]) rtc_mem[i] = 8'($urandom);
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("rst cs_n", cs_n0, 1);
      chk("rst rd_n", rd_n0, 1);
      chk("rst wr_n", wr_n0, 1);
      chk("rst ad_n", ad_n0, 1);
      chk("rst ad_oe", ad_oe0, 0);
      chk("rst ad_out", ad_out0, 0);
      chk("rst le", (le_flat0 == 72'd0), 1);
      chk("rst flags", {les0, llec0, ocup0}, 0);
      chk("rst dut1", {cs_n1, rd_n1, wr_n1, ad_n1, ad_oe1, les1, llec1, ocup1}, 8'hF0);
      chk("rst dut1 bus", {ad_out1, 7'd0, (le_flat1 == 72'd0)}, 16'h0001);
      @(posedge clk); #1 reset = 1'b0;

      wv[0] = 8'h43; wv[1] = 8'h29; wv[2] = 8'h15; wv[3] = 8'h01; wv[4] = 8'h02;
      wv[5] = 8'h13; wv[6] = 8'h57; wv[7] = 8'h40; wv[8] = 8'h23;
      run_seq(0, 1, 0, 4, 4, "wr_spec");

      rtc_mem[8'h21] = 8'h58; rtc_mem[8'h22] = 8'h10; rtc_mem[8'h23] = 8'h09;
      rtc_mem[8'h24] = 8'h28; rtc_mem[8'h25] = 8'h11; rtc_mem[8'h26] = 8'h16;
      rtc_mem[8'h41] = 8'h05; rtc_mem[8'h42] = 8'h30; rtc_mem[8'h43] = 8'h01;
      run_seq(0, 0, 1, 4, 4, "rd_spec");

      foreach (wv[i]) wv[i] = 8'($urandom);
      run_seq(0, 1, 1, 4, 4, "both");

      foreach (rtc_mem[i]) rtc_mem[i] = 8'($urandom);
      run_seq(0, 0, 1, 4, 4, "rd_rand");

      // Abort a read inside its fifth read transaction
      @(posedge clk); #1 req_r0 = 1'b1;
      @(posedge clk); #1 req_r0 = 1'b0;
      repeat (84) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort cs_n", cs_n0, 1);
      chk("abort strobes", {rd_n0, wr_n0, ad_oe0}, 3'b110);
      chk("abort ocupado", ocup0, 0);
      chk("abort le", (le_flat0 == 72'd0), 1);
      @(posedge clk); #1 reset = 1'b0;

      foreach (rtc_mem[i]) rtc_mem[i] = 8'($urandom);
      run_seq(0, 0, 1, 4, 4, "rd_after_rst");

      foreach (wv[i]) wv[i] = 8'($urandom);
      run_seq(1, 1, 0, 1, 2, "wr_fast");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
